axi_config_master: RTL
======================

// Module: axi_config_master
// PURPOSE
// - AXI4 master counterpart of the config-register slave: turns simple register commands into single-beat AXI4 transactions.
// - One outstanding transaction; sits between local control logic (sequencer/CPU shim) and an AXI interconnect slave port.
// - Returns read data / response code on a one-cycle response strobe.
// PARAMETERS
// - ADDR_WIDTH  32  AXI address / command address width
// - DATA_WIDTH  32  AXI data width (8,16,32,64,...)
// - STRB_WIDTH  DATA_WIDTH/8  write strobe width
// - ID_WIDTH    8   AXI ID width
// - AXI_ID      0   constant value driven on awid/arid
// - TIMEOUT_CYCLES 1024  watchdog limit (used only with AXI_CONFIG_MASTER_TIMEOUT_EN)
// PORTS
// - clk  in  1  clock
// - rst  in  1  synchronous, active-high reset
// - cmd_valid  in  1  command request
// - cmd_ready  out 1  command accepted when cmd_valid&cmd_ready
// - cmd_we     in  1  1=write, 0=read
// - cmd_addr   in  ADDR_WIDTH  byte address
// - cmd_wdata  in  DATA_WIDTH  write data
// - cmd_wstrb  in  STRB_WIDTH  write byte enables
// - rsp_valid  out 1  one-cycle completion strobe (no backpressure)
// - rsp_we     out 1  completed command was a write
// - rsp_rdata  out DATA_WIDTH  read data (0 for writes)
// - rsp_resp   out 2  AXI resp of completed transaction
// - rsp_err    out 1  rsp_resp[1] (SLVERR/DECERR)
// - busy       out 1  transaction in flight
// - timeout    out 1  sticky watchdog flag (0 when feature off)
// - m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region}  out  AXI4 AW fields
// - m_axi_awvalid out 1 / m_axi_awready in 1
// - m_axi_w{data,strb,last} out; m_axi_wvalid out 1 / m_axi_wready in 1
// - m_axi_b{id,resp} in; m_axi_bvalid in 1 / m_axi_bready out 1
// - m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region}  out  AXI4 AR fields
// - m_axi_arvalid out 1 / m_axi_arready in 1
// - m_axi_r{id,data,resp,last} in; m_axi_rvalid in 1 / m_axi_rready out 1
// BEHAVIOUR
// - Constants: len=0, size=$clog2(STRB_WIDTH), burst=INCR, lock=0, cache=4'b0011, prot=0, qos=0, region=0, wlast=1, id=AXI_ID.
// - Reset: state IDLE; every valid/ready output, rsp_*, busy, timeout = 0; addr/data regs = 0.
// - FSM IDLE -> (cmd_we) WR | (!cmd_we) RA on cmd handshake; cmd_ready = (state==IDLE), registered-equivalent, 0 during rst.
// - WR: awvalid and wvalid assert cycle after acceptance; each deasserts independently on own handshake; either order or same cycle ok.
//   When both done -> WB; bready=1 in WB; bvalid -> IDLE, rsp_valid next cycle with rsp_we=1, rsp_resp=bresp.
// - RA: arvalid asserts cycle after acceptance; arready -> RR; rready=1 in RR; first rvalid completes -> IDLE,
//   rsp_valid next cycle with rsp_rdata=rdata, rsp_resp=rresp. rlast, bid, rid ignored.
// - Min latency (ready slaves tied 1): write cmd->rsp 4 cycles, read 4 cycles; cmd_ready high again same cycle as rsp_valid.
// - aw/w/ar payload registered at acceptance; stable while valid (AXI rule); never drop valid before handshake.
// - busy = (state!=IDLE) | rsp pending; cmd_valid ignored while busy.
// - rst mid-transaction: outputs return to reset values next edge; no response issued; interconnect reset assumed common.
// CONFIGURATION
// - AXI_CONFIG_MASTER_TIMEOUT_EN defined: counter clears on cmd accept, counts each cycle outside IDLE;
//   reaching TIMEOUT_CYCLES sets sticky timeout=1 (cleared only by rst); FSM keeps waiting (no protocol abort).
// - Not defined: no counter, timeout tied 0.
// TESTING
// - Write addr 0x10 data 0xDEADBEEF strb 0xF, awready delayed 3 cycles, wready=1 -> one AW and one W beat (wlast=1), single rsp_valid, rsp_resp=0, rsp_err=0.
// - Read addr 0x20, slave rdata 0x12345678 OKAY after 5 cycles -> arlen=0, arsize=2, rsp_rdata=0x12345678, rsp_we=0.
// - Write with bresp=2'b10 -> rsp_resp=2, rsp_err=1; read with rresp=2'b11 -> rsp_err=1.
// - cmd_valid held high with 3 queued cmds -> cmd_ready low while busy, exactly 3 transactions, 3 rsp strobes in order.
// - rst asserted while in WB -> next cycle all valids/bready/rsp_valid=0, cmd_ready=1 after rst release.
// - TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held 0 -> timeout=1 at cycle 16, arvalid stays 1; arready later -> normal completion, timeout stays 1.

Source files
------------

// File: rtl/axi_config_master_if.sv
// Command/response port and AXI4 master channels of axi_config_master.
// The master modport is the DUT view; slave is the view of local control plus interconnect.
interface axi_config_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_err;
  logic                  busy;
  logic                  timeout;

  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic [3:0]            m_axi_awqos;
  logic [3:0]            m_axi_awregion;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic [3:0]            m_axi_arqos;
  logic [3:0]            m_axi_arregion;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp, rsp_err, busy, timeout,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
           m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp, rsp_err, busy, timeout,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
           m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_config_master.sv
// Single-outstanding AXI4 master turning register commands into single-beat transactions.
// Optional watchdog: define AXI_CONFIG_MASTER_TIMEOUT_EN for the sticky timeout flag.
module axi_config_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_config_master_if.master        bus
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RR} state_t;

  state_t                r_state,     w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_awvalid,   w_awvalid_nxt;
  logic                  r_wvalid,    w_wvalid_nxt;
  logic                  r_bready,    w_bready_nxt;
  logic                  r_arvalid,   w_arvalid_nxt;
  logic                  r_rready,    w_rready_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic [STRB_WIDTH-1:0] r_wstrb,     w_wstrb_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_we,    w_rsp_we_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]            r_rsp_resp,  w_rsp_resp_nxt;
  logic                  r_busy;
  logic                  w_cmd_fire;
  logic                  w_unused;

  assign w_cmd_fire = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_we    <= w_rsp_we_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) || w_rsp_valid_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_we_nxt    = r_rsp_we;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (w_cmd_fire) begin
          w_cmd_ready_nxt = 1'b0;
          w_addr_nxt      = bus.cmd_addr;
          w_wdata_nxt     = bus.cmd_wdata;
          w_wstrb_nxt     = bus.cmd_wstrb;
          if (bus.cmd_we) begin
            w_state_nxt   = S_WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RA;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      // AW and W retire independently; B is awaited once both are gone
      S_WR: begin
        if (bus.m_axi_awready) w_awvalid_nxt = 1'b0;
        if (bus.m_axi_wready)  w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt  = S_WB;
          w_bready_nxt = 1'b1;
        end
      end
      S_WB: begin
        if (bus.m_axi_bvalid) begin
          w_state_nxt     = S_IDLE;
          w_bready_nxt    = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_we_nxt    = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = bus.m_axi_bresp;
        end
      end
      S_RA: begin
        if (bus.m_axi_arready) begin
          w_state_nxt   = S_RR;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      S_RR: begin
        if (bus.m_axi_rvalid) begin
          w_state_nxt     = S_IDLE;
          w_rready_nxt    = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_we_nxt    = 1'b0;
          w_rsp_rdata_nxt = bus.m_axi_rdata;
          w_rsp_resp_nxt  = bus.m_axi_rresp;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef AXI_CONFIG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout;

  // Watchdog saturates at the limit; the flag stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_cmd_fire) begin
      r_wd_cnt  <= '0;
    end else if ((r_state != S_IDLE) && (r_wd_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      if (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign w_unused = ^{bus.m_axi_bid, bus.m_axi_rid, bus.m_axi_rlast, 1'(TIMEOUT_CYCLES % 2)};

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_resp  = r_rsp_resp;
  assign bus.rsp_err   = r_rsp_resp[1];
  assign bus.busy      = r_busy;

  assign bus.m_axi_awid     = ID_WIDTH'(AXI_ID);
  assign bus.m_axi_awaddr   = r_addr;
  assign bus.m_axi_awlen    = 8'd0;
  assign bus.m_axi_awsize   = 3'($clog2(STRB_WIDTH));
  assign bus.m_axi_awburst  = 2'b01;
  assign bus.m_axi_awlock   = 1'b0;
  assign bus.m_axi_awcache  = 4'b0011;
  assign bus.m_axi_awprot   = 3'b000;
  assign bus.m_axi_awqos    = 4'd0;
  assign bus.m_axi_awregion = 4'd0;
  assign bus.m_axi_awvalid  = r_awvalid;

  assign bus.m_axi_wdata    = r_wdata;
  assign bus.m_axi_wstrb    = r_wstrb;
  assign bus.m_axi_wlast    = 1'b1;
  assign bus.m_axi_wvalid   = r_wvalid;
  assign bus.m_axi_bready   = r_bready;

  assign bus.m_axi_arid     = ID_WIDTH'(AXI_ID);
  assign bus.m_axi_araddr   = r_addr;
  assign bus.m_axi_arlen    = 8'd0;
  assign bus.m_axi_arsize   = 3'($clog2(STRB_WIDTH));
  assign bus.m_axi_arburst  = 2'b01;
  assign bus.m_axi_arlock   = 1'b0;
  assign bus.m_axi_arcache  = 4'b0011;
  assign bus.m_axi_arprot   = 3'b000;
  assign bus.m_axi_arqos    = 4'd0;
  assign bus.m_axi_arregion = 4'd0;
  assign bus.m_axi_arvalid  = r_arvalid;
  assign bus.m_axi_rready   = r_rready;

endmodule
